alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 151 +++++++++++++++
 tb/tb_alu_issue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Single-issue ALU sequencer: decodes RV32I OP/OP-IMM, drives an external combinational ALU,
// writes back to a 32x32 register file. Define ALU_ISSUE_TRAP_EN to add the illegal-instruction pulse.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_wd,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
`ifdef ALU_ISSUE_TRAP_EN
  output logic        illegal,
`endif
  output logic [1:0]  dbg_state
);

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and the source must hold in_instr until it transfers.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t      state;
  logic [31:0] instr;
  logic [31:0] result;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1v, rs2v, imm;
  logic [5:0]  dec_op;
  logic [31:0] dec_b;
  logic        legal;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm    = {{20{instr[31]}}, instr[31:20]};
  assign rs1v   = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2v   = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // Decoder: dec_op stays 0 for anything not recognised, which doubles as the illegal flag.
  always_comb begin
    dec_op = 6'd0;
    dec_b  = 32'd0;
    case (opcode)
      7'b0110011: begin
        case (funct3)
          3'b000: if (funct7 == 7'b0000000) dec_op = 6'd1;
                  else if (funct7 == 7'b0100000) dec_op = 6'd2;
          3'b001: if (funct7 == 7'b0000000) dec_op = 6'd6;
          3'b010: if (funct7 == 7'b0000000) dec_op = 6'd9;
          3'b011: if (funct7 == 7'b0000000) dec_op = 6'd10;
          3'b100: if (funct7 == 7'b0000000) dec_op = 6'd3;
          3'b101: if (funct7 == 7'b0000000) dec_op = 6'd8;
                  else if (funct7 == 7'b0100000) dec_op = 6'd7;
          3'b110: if (funct7 == 7'b0000000) dec_op = 6'd4;
          default: if (funct7 == 7'b0000000) dec_op = 6'd5;
        endcase
        dec_b = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'd0, rs2v[4:0]} : rs2v;
      end
      7'b0010011: begin
        case (funct3)
          3'b000:  dec_op = 6'd1;
          3'b001:  if (funct7 == 7'b0000000) dec_op = 6'd6;
          3'b010:  dec_op = 6'd9;
          3'b011:  dec_op = 6'd10;
          3'b100:  dec_op = 6'd3;
          3'b101:  if (funct7 == 7'b0000000) dec_op = 6'd8;
                   else if (funct7 == 7'b0100000) dec_op = 6'd7;
          3'b110:  dec_op = 6'd4;
          default: dec_op = 6'd5;
        endcase
        dec_b = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'd0, instr[24:20]} : imm;
      end
      default: begin
        dec_op = 6'd0;
        dec_b  = 32'd0;
      end
    endcase
  end

  assign legal = (dec_op != 6'd0);

  // ALU operands are read live in EXEC so the previous writeback is already visible.
  assign alu_op    = (state == EXEC) ? dec_op : 6'd0;
  assign alu_a     = (state == EXEC && legal) ? rs1v  : 32'd0;
  assign alu_b     = (state == EXEC && legal) ? dec_b : 32'd0;
  assign wb_data   = wb_valid ? result : 32'd0;
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : rf[dbg_raddr];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      instr    <= 32'd0;
      result   <= 32'd0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
`ifdef ALU_ISSUE_TRAP_EN
      illegal  <= 1'b0;
`endif
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            instr    <= in_instr;
            in_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          result   <= legal ? alu_wd : 32'd0;
          wb_valid <= legal;
          wb_rd    <= legal ? rd : 5'd0;
`ifdef ALU_ISSUE_TRAP_EN
          illegal  <= ~legal;
`endif
          state    <= WB;
        end
        WB: begin
          if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= result;
          wb_valid <= 1'b0;
          wb_rd    <= 5'd0;
`ifdef ALU_ISSUE_TRAP_EN
          illegal  <= 1'b0;
`endif
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: hand-computed expected writebacks go through a scoreboard queue.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_wd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [1:0]  dbg_state;
`ifdef ALU_ISSUE_TRAP_EN
  logic        illegal;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [37:0] exp_q[$];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_wd(alu_wd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
`ifdef ALU_ISSUE_TRAP_EN
    .illegal(illegal),
`endif
    .dbg_state(dbg_state)
  );

  // Reference combinational ALU sitting outside the unit.
  always_comb begin
    alu_wd = 32'd0;
    case (alu_op)
      6'd1:  alu_wd = alu_a + alu_b;
      6'd2:  alu_wd = alu_a - alu_b;
      6'd3:  alu_wd = alu_a ^ alu_b;
      6'd4:  alu_wd = alu_a | alu_b;
      6'd5:  alu_wd = alu_a & alu_b;
      6'd6:  alu_wd = alu_a << alu_b[4:0];
      6'd7:  alu_wd = $signed(alu_a) >>> alu_b[4:0];
      6'd8:  alu_wd = alu_a >> alu_b[4:0];
      6'd9:  alu_wd = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'd10: alu_wd = {31'd0, alu_a < alu_b};
      default: alu_wd = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    dbg_raddr = r;
    #1;
    chk(tag, {6'd0, dbg_rdata}, {6'd0, exp});
  endtask

  // Issue one instruction from IDLE; exp_b_chk enables the alu_b check in EXEC.
  task automatic issue(input string tag, input logic [31:0] ins, input logic [5:0] exp_op,
                       input logic ev, input logic [4:0] erd, input logic [31:0] edata,
                       input logic exp_b_chk, input logic [31:0] exp_b);
    logic [37:0] got, want;
    int waited = 0;
    while (!in_ready && waited < 10) begin
      tick();
      waited++;
    end
    chk({tag, "_ready"}, {37'd0, in_ready}, 38'd1);
    in_valid = 1'b1;
    in_instr = ins;
    tick();
    exp_q.push_back({ev, erd, edata});
    in_valid = 1'b0;
    in_instr = $urandom;
    chk({tag, "_op"}, {32'd0, alu_op}, {32'd0, exp_op});
    chk({tag, "_exec_nowb"}, {37'd0, wb_valid}, 38'd0);
    if (exp_b_chk) chk({tag, "_b"}, {6'd0, alu_b}, {6'd0, exp_b});
    tick();
    got = {wb_valid, wb_rd, wb_data};
    want = exp_q.pop_front();
    chk({tag, "_wb"}, got, want);
`ifdef ALU_ISSUE_TRAP_EN
    chk({tag, "_illegal"}, {37'd0, illegal}, {37'd0, ~ev});
`endif
    tick();
    chk({tag, "_idle"}, {36'd0, dbg_state}, 38'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'd0;
    dbg_raddr = 5'd0;
    tick();
    tick();
    chk("rst_ready", {37'd0, in_ready}, 38'd1);
    chk("rst_wb", {wb_valid, wb_rd, wb_data}, 38'd0);
    chk("rst_op", {32'd0, alu_op}, 38'd0);
    rst = 1'b0;
    tick();
    chk("idle_state", {36'd0, dbg_state}, 38'd0);

    issue("addi_x1", 32'hFFB00093, 6'd1, 1'b1, 5'd1, 32'hFFFFFFFB, 1'b0, 32'd0);
    chk_reg("x1", 5'd1, 32'hFFFFFFFB);
    issue("addi_x2", 32'h00300113, 6'd1, 1'b1, 5'd2, 32'd3, 1'b1, 32'd3);
    issue("sub_x3", 32'h402081B3, 6'd2, 1'b1, 5'd3, 32'hFFFFFFF8, 1'b1, 32'd3);
    chk_reg("x3", 5'd3, 32'hFFFFFFF8);
    issue("sltu_x4", 32'h00113233, 6'd10, 1'b1, 5'd4, 32'd1, 1'b1, 32'hFFFFFFFB);
    chk_reg("x4", 5'd4, 32'd1);
    issue("addi_x2b", 32'h02300113, 6'd1, 1'b1, 5'd2, 32'h23, 1'b0, 32'd0);
    issue("sll_x5", 32'h002112B3, 6'd6, 1'b1, 5'd5, 32'h118, 1'b1, 32'd3);
    chk_reg("x5", 5'd5, 32'h118);
    issue("srai_x7", 32'h4040D393, 6'd7, 1'b1, 5'd7, 32'hFFFFFFFF, 1'b1, 32'd4);
    issue("xor_x8", 32'h0020C433, 6'd3, 1'b1, 5'd8, 32'hFFFFFFD8, 1'b0, 32'd0);
    issue("slt_x9", 32'h0020A4B3, 6'd9, 1'b1, 5'd9, 32'd1, 1'b0, 32'd0);
    issue("srl_x10", 32'h0020D533, 6'd8, 1'b1, 5'd10, 32'h1FFFFFFF, 1'b1, 32'd3);
    issue("addi_x0", 32'h00700013, 6'd1, 1'b1, 5'd0, 32'd7, 1'b0, 32'd0);
    chk_reg("x0", 5'd0, 32'd0);
    issue("bad_f7", 32'h02000033, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    issue("lui", 32'h123450B7, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    chk_reg("x1_kept", 5'd1, 32'hFFFFFFFB);

    // in_valid held high: in_ready must be high one cycle in three.
    in_valid = 1'b1;
    in_instr = 32'h00158593;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("tput_ready_%0d", k), {37'd0, in_ready}, {37'd0, (k % 3) == 0});
      tick();
    end
    in_valid = 1'b0;
    chk_reg("x11", 5'd11, 32'd3);

    // Reset in EXEC aborts the write and clears the file.
    in_valid = 1'b1;
    in_instr = 32'h00900313;
    tick();
    in_valid = 1'b0;
    chk("abort_in_exec", {36'd0, dbg_state}, 38'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_idle", {36'd0, dbg_state}, 38'd0);
    chk("abort_ready", {37'd0, in_ready}, 38'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort_nowb_%0d", k), {37'd0, wb_valid}, 38'd0);
      tick();
    end
    chk_reg("x6_zero", 5'd6, 32'd0);
    chk_reg("x1_cleared", 5'd1, 32'd0);

    issue("post_rst", 32'h00900313, 6'd1, 1'b1, 5'd6, 32'd9, 1'b0, 32'd0);
    chk_reg("x6", 5'd6, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
